axis_rr_arb: RTL and testbench
==============================

# axis_rr_arb

Round-robin, packet-locked arbiter that shares one AXI-Stream sink between N stream sources. It sits in front of the AXI-lite-to-stream bridge's stream side so that several producers (CPU write path, debug port, DMA) can use one downstream stream without interleaving beats of different packets. Grant is held from the first accepted beat until the accepted `tlast` beat. Output passes through a one-entry register stage.

## Interface
- `N`, 2: number of sources, ≥1.
- `DATA_W`, 32: tdata width per source.
- `ID_W`, derived as max(1, $clog2(N)): width of `m_tid`; localparam, not overridable.

- `aclk`  in  1  clock.
- `aresetn`  in  1  reset; synchronous, active-low.
- `s_tdata`  in  N*DATA_W  source data; source i at [i*DATA_W +: DATA_W].
- `s_tvalid`  in  N  per-source valid.
- `s_tlast`  in  N  per-source end of packet.
- `s_tready`  out  N  per-source ready; at most one bit high.
- `m_tdata`  out  DATA_W  registered output data.
- `m_tvalid`  out  1  registered output valid.
- `m_tlast`  out  1  registered output last.
- `m_tid`  out  ID_W  index of the source that produced the beat.
- `m_tready`  in  1  sink ready.
- `busy`  out  1  high while the arbiter is in state BUSY.

## Operation
- State machine, 2 states:
  - **IDLE.** If any `s_tvalid` is set, select the first set bit scanning from `last_grant+1` upward, modulo N. Register the selection in `grant` and go to BUSY. Otherwise stay in IDLE.
  - **BUSY.** `s_tready[grant] = !m_tvalid || m_tready`; all other `s_tready` bits are 0. A beat is accepted when `s_tvalid[grant] && s_tready[grant]`. On acceptance, the output register loads `s_tdata` slice, `s_tlast`, and `m_tid = grant`, and sets `m_tvalid = 1`. On an accepted beat with `s_tlast = 1`: `last_grant <= grant`, go to IDLE.
- Output register:
  - If `m_tvalid && m_tready` and no new beat is accepted in the same cycle, then `m_tvalid <= 0`.
  - Accepting a new beat and draining the old one in the same cycle is legal.
- Grant never changes in BUSY, whatever the other sources do.
- Granted source drops `s_tvalid` mid-packet: the arbiter stays in BUSY on that source and waits. There is no timeout.
- `s_tready` is 0 in IDLE. `s_tready` never depends combinationally on `s_tvalid`.
- `m_tdata`, `m_tlast` and `m_tid` hold their values while `m_tvalid && !m_tready`.
- N=1: `grant` is always 0 and `m_tid` is 0. Sequencing is otherwise unchanged.
- Reset values:
  - state IDLE, `busy` 0, `grant` 0.
  - `last_grant` N-1, so source 0 has first priority.
  - `s_tready` 0.
  - `m_tvalid`, `m_tlast`, `m_tdata` and `m_tid` all 0.
- Reset asserted mid-packet: all state clears on that edge, and any beat in the output register is discarded. The packet's remainder is treated as a new packet after reset.

## Timing
- Source raises `s_tvalid` in cycle 0 while the arbiter is in IDLE:
  - grant registers at edge 1.
  - `s_tready` is high in cycle 1.
  - the first beat is accepted at edge 2.
  - `m_tvalid` is high in cycle 2.
- Within a packet: 1 beat/cycle while `m_tready` stays high.
- Between packets: exactly one IDLE cycle after the `tlast` acceptance edge. Source acceptance drops for 1 cycle. The output may still drain during it.
- Backpressure: `m_tready` low with `m_tvalid` high forces `s_tready` low in the same cycle.

## Test plan
- **Single source, 4-beat packet.** Src0 sends 0xA0..0xA3 with `tlast` on 0xA3, `m_tready` = 1.
  - `m_tvalid` goes high 2 cycles after `s_tvalid`.
  - Beats emerge in order with `m_tid` = 0 and `m_tlast` only on 0xA3.
  - `busy` drops the cycle after the last acceptance.
- **Contention, N=2.** Both sources hold 2-beat packets continuously (src0 0x1x, src1 0x2x).
  - Output packet order is src0, src1, src0, src1.
  - No interleaving within a packet.
  - One acceptance bubble between packets.
- **Backpressure.** Hold `m_tready` = 0 for 3 cycles mid-packet.
  - `m_tdata` is stable throughout.
  - `s_tready[grant]` is 0 throughout.
  - No beat is lost or duplicated after release.
- **Mid-packet valid gap.** Granted src1 drops `s_tvalid` for 5 cycles while src0 requests.
  - Grant stays on src1.
  - src0's `s_tready` stays 0 until src1's `tlast` is accepted.
- **Single-beat packets.** `tlast` is set on every beat.
  - Each beat is a complete packet and is followed by one IDLE cycle.
- **Reset mid-packet.** Deassert `aresetn` for 1 cycle after beat 2 of a 4-beat packet.
  - Next cycle: `m_tvalid` = 0, `busy` = 0, all `s_tready` = 0.
  - Arbitration restarts with source 0 first.

Source files
------------

// File: rtl/axis_rr_arb.sv
// Round-robin AXI-Stream arbiter. A grant is held for a whole packet, from the
// first accepted beat through the accepted tlast beat, behind a one-entry output register.
module axis_rr_arb #(
  parameter int N      = 2,
  parameter int DATA_W = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [N*DATA_W-1:0]   s_tdata,
  input  logic [N-1:0]          s_tvalid,
  input  logic [N-1:0]          s_tlast,
  output logic [N-1:0]          s_tready,
  output logic [DATA_W-1:0]     m_tdata,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] m_tid,
  input  logic                  m_tready,
  output logic                  busy
);

  localparam int ID_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic              m_tvalid_q, m_tvalid_d;
  logic              m_tlast_q, m_tlast_d;
  logic [DATA_W-1:0] m_tdata_q, m_tdata_d;
  logic [ID_W-1:0]   m_tid_q, m_tid_d;

  logic              sel_valid;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;
  logic              grant_ready;
  logic              accept;
  logic [2*N-1:0]    rot_valid;
  logic              pick_found;
  logic [ID_W-1:0]   pick_idx;
  int                pick_pos;

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_q == ID_W'(i)) begin
        sel_valid = s_tvalid[i];
        sel_last  = s_tlast[i];
        sel_data  = s_tdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Source ready depends only on registered state and the sink, never on s_tvalid.
  assign grant_ready = (state_q == BUSY) && (!m_tvalid_q || m_tready);
  assign accept      = grant_ready && sel_valid;

  always_comb begin
    s_tready = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_q == ID_W'(i)) s_tready[i] = grant_ready;
    end
  end

  // Rotate the request vector so bit 0 is the source just after last_grant.
  always_comb begin
    rot_valid  = {s_tvalid, s_tvalid} >> (32'(last_grant_q) + 32'd1);
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_pos   = 0;
    for (int k = 0; k < N; k++) begin
      if (!pick_found && rot_valid[k]) begin
        pick_found = 1'b1;
        pick_pos   = int'(last_grant_q) + 1 + k;
        if (pick_pos >= N) pick_pos = pick_pos - N;
        pick_idx   = ID_W'(pick_pos);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    m_tvalid_d   = m_tvalid_q;
    m_tlast_d    = m_tlast_q;
    m_tdata_d    = m_tdata_q;
    m_tid_d      = m_tid_q;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (accept && sel_last) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      m_tvalid_d = 1'b1;
      m_tlast_d  = sel_last;
      m_tdata_d  = sel_data;
      m_tid_d    = grant_q;
    end else if (m_tvalid_q && m_tready) begin
      m_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_W'(N - 1);
      m_tvalid_q   <= 1'b0;
      m_tlast_q    <= 1'b0;
      m_tdata_q    <= '0;
      m_tid_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      m_tvalid_q   <= m_tvalid_d;
      m_tlast_q    <= m_tlast_d;
      m_tdata_q    <= m_tdata_d;
      m_tid_q      <= m_tid_d;
    end
  end

  assign m_tvalid = m_tvalid_q;
  assign m_tlast  = m_tlast_q;
  assign m_tdata  = m_tdata_q;
  assign m_tid    = m_tid_q;
  assign busy     = (state_q == BUSY);

endmodule

// File: tb/tb_axis_rr_arb.sv
// Directed bench for axis_rr_arb with two sources: reset, single packet, contention,
// backpressure, mid-packet valid gap, single-beat packets and reset mid-packet.
module tb_axis_rr_arb;

  localparam int N      = 2;
  localparam int DATA_W = 32;
  localparam int ID_W   = 1;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } beat_t;

  typedef struct packed {
    logic [ID_W-1:0] tid;
    logic            last;
    logic [31:0]     data;
  } obs_t;

  typedef struct packed {
    logic [1:0]  src;
    logic [31:0] t;
  } acc_t;

  logic                aclk = 1'b0;
  logic                aresetn = 1'b0;
  logic [N*DATA_W-1:0] s_tdata;
  logic [N-1:0]        s_tvalid;
  logic [N-1:0]        s_tlast;
  logic [N-1:0]        s_tready;
  logic [DATA_W-1:0]   m_tdata;
  logic                m_tvalid;
  logic                m_tlast;
  logic [ID_W-1:0]     m_tid;
  logic                m_tready;
  logic                busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  beat_t q0[$];
  beat_t q1[$];
  logic  hold0 = 1'b0;
  logic  hold1 = 1'b0;
  obs_t  out_q[$];
  acc_t  acc_q[$];

  axis_rr_arb #(.N(N), .DATA_W(DATA_W)) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tlast  (m_tlast),
    .m_tid    (m_tid),
    .m_tready (m_tready),
    .busy     (busy)
  );

  always #5 aclk = ~aclk;

  // Record every output transfer and source acceptance with its edge number.
  always @(posedge aclk) begin
    cyc++;
    if (aresetn) begin
      if (m_tvalid && m_tready) out_q.push_back('{tid: m_tid, last: m_tlast, data: m_tdata});
      for (int i = 0; i < N; i++) begin
        if (s_tvalid[i] && s_tready[i]) acc_q.push_back('{src: 2'(i), t: 32'(cyc)});
      end
    end
  end

  task automatic drive();
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    if (q0.size() > 0) begin
      s_tvalid[0]     = !hold0;
      s_tlast[0]      = q0[0].last;
      s_tdata[31:0]   = q0[0].data;
    end
    if (q1.size() > 0) begin
      s_tvalid[1]     = !hold1;
      s_tlast[1]      = q1[0].last;
      s_tdata[63:32]  = q1[0].data;
    end
  endtask

  task automatic step();
    logic [N-1:0] hs;
    @(negedge aclk);
    hs = s_tvalid & s_tready & {N{aresetn}};
    @(posedge aclk);
    #1;
    if (hs[0]) void'(q0.pop_front());
    if (hs[1]) void'(q1.pop_front());
    drive();
  endtask

  task automatic do_reset();
    q0.delete();
    q1.delete();
    hold0 = 1'b0;
    hold1 = 1'b0;
    aresetn = 1'b0;
    drive();
    step();
    step();
    aresetn = 1'b1;
  endtask

  task automatic run_until_idle(input int max_cycles);
    bit done;
    done = 1'b0;
    for (int k = 0; k < max_cycles; k++) begin
      if (q0.size() == 0 && q1.size() == 0 && !m_tvalid && !busy) begin
        done = 1'b1;
        break;
      end
      step();
    end
    total++;
    if (!done) begin
      bad++;
      $display("[TB] FAIL run_timeout: got busy=%0b m_tvalid=%0b q0=%0d q1=%0d, required idle within %0d cycles",
               busy, m_tvalid, q0.size(), q1.size(), max_cycles);
    end
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    q0.delete();
    q1.delete();
    q0.push_back('{last: 1'b1, data: 32'hDEAD});
    aresetn = 1'b0;
    drive();
    step();
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b need 0", busy); end
    total++; if (s_tready !== 2'b00) begin bad++; $display("[TB] FAIL reset_tready: got %b need 00", s_tready); end
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_mvalid: got %b need 0", m_tvalid); end
    total++; if (m_tdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_mdata: got %h need 0", m_tdata); end
    total++; if (m_tlast !== 1'b0 || m_tid !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_mlast_tid: got %b/%b need 0/0", m_tlast, m_tid);
    end
    q0.delete();
    aresetn = 1'b1;
    drive();
  endtask

  task automatic test_single();
    logic        e_busy[1:6] = '{1, 1, 1, 1, 0, 0};
    logic [1:0]  e_rdy[1:6]  = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
    logic        e_mv[1:6]   = '{0, 1, 1, 1, 1, 0};
    logic [31:0] e_md[1:6]   = '{32'h0, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'h0};
    logic        e_ml[1:6]   = '{0, 0, 0, 0, 1, 0};
    $display("[TB] test_single");
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) q0.push_back('{last: (i == 3), data: 32'hA0 + 32'(i)});
    drive();
    total++; if (m_tvalid !== 1'b0 || s_tready !== 2'b00 || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL single_c0: got mv=%b rdy=%b busy=%b need 0/00/0", m_tvalid, s_tready, busy);
    end
    for (int c = 1; c <= 6; c++) begin
      step();
      total++; if (busy !== e_busy[c]) begin bad++; $display("[TB] FAIL single_busy c%0d: got %b need %b", c, busy, e_busy[c]); end
      total++; if (s_tready !== e_rdy[c]) begin bad++; $display("[TB] FAIL single_rdy c%0d: got %b need %b", c, s_tready, e_rdy[c]); end
      total++; if (m_tvalid !== e_mv[c]) begin bad++; $display("[TB] FAIL single_mv c%0d: got %b need %b", c, m_tvalid, e_mv[c]); end
      if (e_mv[c]) begin
        total++; if (m_tdata !== e_md[c] || m_tlast !== e_ml[c] || m_tid !== 1'b0) begin
          bad++; $display("[TB] FAIL single_beat c%0d: got %h/%b/%b need %h/%b/0", c, m_tdata, m_tlast, m_tid, e_md[c], e_ml[c]);
        end
      end
    end
  endtask

  task automatic test_contention();
    obs_t exp_o[8];
    int   exp_gap[7] = '{1, 2, 1, 2, 1, 2, 1};
    $display("[TB] test_contention");
    do_reset();
    out_q.delete();
    acc_q.delete();
    m_tready = 1'b1;
    q0.push_back('{last: 1'b0, data: 32'h10}); q0.push_back('{last: 1'b1, data: 32'h11});
    q0.push_back('{last: 1'b0, data: 32'h12}); q0.push_back('{last: 1'b1, data: 32'h13});
    q1.push_back('{last: 1'b0, data: 32'h20}); q1.push_back('{last: 1'b1, data: 32'h21});
    q1.push_back('{last: 1'b0, data: 32'h22}); q1.push_back('{last: 1'b1, data: 32'h23});
    exp_o = '{'{0, 0, 32'h10}, '{0, 1, 32'h11}, '{1, 0, 32'h20}, '{1, 1, 32'h21},
              '{0, 0, 32'h12}, '{0, 1, 32'h13}, '{1, 0, 32'h22}, '{1, 1, 32'h23}};
    drive();
    run_until_idle(60);
    total++; if (out_q.size() != 8) begin bad++; $display("[TB] FAIL cont_count: got %0d need 8", out_q.size()); end
    for (int i = 0; i < 8 && i < out_q.size(); i++) begin
      total++; if (out_q[i] !== exp_o[i]) begin
        bad++; $display("[TB] FAIL cont_beat%0d: got %h need %h", i, out_q[i], exp_o[i]);
      end
    end
    total++; if (acc_q.size() != 8) begin bad++; $display("[TB] FAIL cont_acc_count: got %0d need 8", acc_q.size()); end
    for (int i = 0; i < 7 && i + 1 < acc_q.size(); i++) begin
      total++; if (int'(acc_q[i+1].t - acc_q[i].t) != exp_gap[i]) begin
        bad++; $display("[TB] FAIL cont_gap%0d: got %0d need %0d", i, acc_q[i+1].t - acc_q[i].t, exp_gap[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    $display("[TB] test_backpressure");
    out_q.delete();
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) q0.push_back('{last: (i == 3), data: 32'hB0 + 32'(i)});
    drive();
    step();
    step();
    m_tready = 1'b0;
    for (int c = 2; c <= 4; c++) begin
      #1;
      total++; if (m_tvalid !== 1'b1 || m_tdata !== 32'hB0) begin
        bad++; $display("[TB] FAIL bp_hold c%0d: got mv=%b data=%h need 1/b0", c, m_tvalid, m_tdata);
      end
      total++; if (s_tready !== 2'b00) begin bad++; $display("[TB] FAIL bp_rdy c%0d: got %b need 00", c, s_tready); end
      step();
    end
    m_tready = 1'b1;
    run_until_idle(40);
    total++; if (out_q.size() != 4) begin bad++; $display("[TB] FAIL bp_count: got %0d need 4", out_q.size()); end
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      total++; if (out_q[i].data !== 32'hB0 + 32'(i) || out_q[i].last !== (i == 3)) begin
        bad++; $display("[TB] FAIL bp_beat%0d: got %h/%b need %h/%b", i, out_q[i].data, out_q[i].last, 32'hB0 + 32'(i), (i == 3));
      end
    end
  endtask

  task automatic test_gap();
    logic [1:0]  exp_src[4] = '{2'd1, 2'd1, 2'd1, 2'd0};
    logic [31:0] exp_dat[4] = '{32'h30, 32'h31, 32'h32, 32'h40};
    $display("[TB] test_gap");
    out_q.delete();
    acc_q.delete();
    m_tready = 1'b1;
    q1.push_back('{last: 1'b0, data: 32'h30});
    q1.push_back('{last: 1'b0, data: 32'h31});
    q1.push_back('{last: 1'b1, data: 32'h32});
    q0.push_back('{last: 1'b1, data: 32'h40});
    drive();
    step();
    total++; if (s_tready !== 2'b10) begin bad++; $display("[TB] FAIL gap_grant: got %b need 10", s_tready); end
    hold1 = 1'b1;
    step();
    for (int g = 0; g < 5; g++) begin
      total++; if (busy !== 1'b1 || s_tready !== 2'b10) begin
        bad++; $display("[TB] FAIL gap_hold%0d: got busy=%b rdy=%b need 1/10", g, busy, s_tready);
      end
      if (g == 4) hold1 = 1'b0;
      step();
    end
    run_until_idle(40);
    total++; if (acc_q.size() != 4) begin bad++; $display("[TB] FAIL gap_count: got %0d need 4", acc_q.size()); end
    for (int i = 0; i < 4 && i < acc_q.size() && i < out_q.size(); i++) begin
      total++; if (acc_q[i].src !== exp_src[i] || out_q[i].data !== exp_dat[i] || out_q[i].tid !== exp_src[i][0]) begin
        bad++; $display("[TB] FAIL gap_order%0d: got src=%0d data=%h tid=%b need %0d/%h", i, acc_q[i].src, out_q[i].data, out_q[i].tid, exp_src[i], exp_dat[i]);
      end
    end
  endtask

  task automatic test_single_beat();
    $display("[TB] test_single_beat");
    out_q.delete();
    acc_q.delete();
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) q0.push_back('{last: 1'b1, data: 32'h50 + 32'(i)});
    drive();
    run_until_idle(40);
    total++; if (acc_q.size() != 3 || out_q.size() != 3) begin
      bad++; $display("[TB] FAIL sb_count: got acc=%0d out=%0d need 3/3", acc_q.size(), out_q.size());
    end
    for (int i = 0; i + 1 < acc_q.size(); i++) begin
      total++; if (acc_q[i+1].t - acc_q[i].t != 32'd2) begin
        bad++; $display("[TB] FAIL sb_gap%0d: got %0d need 2", i, acc_q[i+1].t - acc_q[i].t);
      end
    end
    for (int i = 0; i < out_q.size() && i < 3; i++) begin
      total++; if (out_q[i] !== obs_t'{tid: 1'b0, last: 1'b1, data: 32'h50 + 32'(i)}) begin
        bad++; $display("[TB] FAIL sb_beat%0d: got %h need last=1 data=%h", i, out_q[i], 32'h50 + 32'(i));
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t exp_o[3];
    $display("[TB] test_reset_mid");
    do_reset();
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) q1.push_back('{last: (i == 3), data: 32'h60 + 32'(i)});
    drive();
    step();
    step();
    step();
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    total++; if (m_tvalid !== 1'b0 || busy !== 1'b0 || s_tready !== 2'b00) begin
      bad++; $display("[TB] FAIL rstmid_clear: got mv=%b busy=%b rdy=%b need 0/0/00", m_tvalid, busy, s_tready);
    end
    total++; if (q1.size() != 2) begin bad++; $display("[TB] FAIL rstmid_remaining: got %0d need 2", q1.size()); end
    out_q.delete();
    acc_q.delete();
    q0.push_back('{last: 1'b1, data: 32'h70});
    exp_o = '{'{0, 1, 32'h70}, '{1, 0, 32'h62}, '{1, 1, 32'h63}};
    drive();
    run_until_idle(40);
    total++; if (out_q.size() != 3) begin bad++; $display("[TB] FAIL rstmid_count: got %0d need 3", out_q.size()); end
    for (int i = 0; i < 3 && i < out_q.size(); i++) begin
      total++; if (out_q[i] !== exp_o[i]) begin
        bad++; $display("[TB] FAIL rstmid_beat%0d: got %h need %h", i, out_q[i], exp_o[i]);
      end
    end
  endtask

  initial begin
    m_tready = 1'b1;
    drive();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_gap();
    test_single_beat();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
